latch_strobe_tx: RTL and testbench

//   Write-side driver for transparent D-latch banks (q follows d while e=1).

---
 rtl/latch_strobe_tx.sv | 129 ++++++++++++
 tb/tb_latch_strobe_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_strobe_tx.sv
// latch_strobe_tx: write-side driver for a transparent D-latch bank.
// Each accepted word is driven onto d, then framed by an e pulse with
// SETUP_CYC setup cycles before it, PULSE_CYC cycles of e=1, and HOLD_CYC
// hold cycles after it. d and e are registered, so the latch never sees a
// glitch on e or a d change while e is high.
module latch_strobe_tx #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             e,
  output logic             busy,
  output logic             done
);

  localparam int MAXP_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXP    = (MAXP_SP > HOLD_CYC) ? MAXP_SP : HOLD_CYC;
  localparam int CW      = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_e;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_d_nxt;
  logic             w_e_nxt;
  logic             w_done_nxt;
  logic             w_cnt_zero;
  logic [CW-1:0]    w_cnt_dec;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = r_cnt - CW'(1);

  // State register plus registered d/e/done; reset drops e immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_e     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= w_d_nxt;
      r_e     <= w_e_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic. done is computed one cycle early so the registered
  // copy is high exactly in the HOLD cycle where the counter reads zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = r_d;
    w_e_nxt     = r_e;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_e_nxt = 1'b0;
        if (in_valid) begin
          w_d_nxt     = in_data;
          w_cnt_nxt   = SETUP_LD;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_e_nxt     = 1'b1;
          w_cnt_nxt   = PULSE_LD;
          w_state_nxt = ST_STROBE;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          w_e_nxt     = 1'b0;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = ST_HOLD;
          w_done_nxt  = (HOLD_LD == '0);
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt  = w_cnt_dec;
          w_done_nxt = (r_cnt == CW'(1));
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_e_nxt     = 1'b0;
      end
    endcase
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign d        = r_d;
  assign e        = r_e;
  assign done     = r_done;

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Bench for latch_strobe_tx: two instances (default timing and 1/1/1
// timing) against a cycle-offset reference model, with a done-driven
// scoreboard and a transparent latch model on d/e.
module tb_latch_strobe_tx;

  localparam int SA = 2, PA = 3, HA = 1;
  localparam int SB = 1, PB = 1, HB = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iv   [2];
  logic [7:0] idat [2];
  logic [7:0] od   [2];
  logic       oe   [2];
  logic       ordy [2];
  logic       obusy[2];
  logic       odone[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  latch_strobe_tx #(.WIDTH(8), .SETUP_CYC(SA), .PULSE_CYC(PA), .HOLD_CYC(HA)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ordy[0]),
    .d(od[0]), .e(oe[0]), .busy(obusy[0]), .done(odone[0]));

  latch_strobe_tx #(.WIDTH(8), .SETUP_CYC(SB), .PULSE_CYC(PB), .HOLD_CYC(HB)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ordy[1]),
    .d(od[1]), .e(oe[1]), .busy(obusy[1]), .done(odone[1]));

  function automatic int sp(input int i); return (i == 0) ? SA : SB; endfunction
  function automatic int pp(input int i); return (i == 0) ? PA : PB; endfunction
  function automatic int per(input int i); return (i == 0) ? SA + PA + HA : SB + PB + HB; endfunction

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Reference model: a word accepted at the end of cycle t occupies cycles
  // t+1..t+S+P+H; e is high for offsets S+1..S+P, done at offset S+P+H.
  typedef struct { logic [7:0] data; int acc; } rec_t;
  rec_t sb0[$];
  rec_t sb1[$];

  bit         mb  [2];
  int         mk  [2];
  logic [7:0] md  [2];
  logic [7:0] mq  [2];
  bit         mqv [2];
  bit         acc [2];
  int         lacc[2];
  logic [7:0] q   [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        mb[i] = 1'b0; mk[i] = 0; md[i] = '0;
      end else if (!mb[i]) begin
        if (iv[i] === 1'b1) begin
          mb[i] = 1'b1; mk[i] = 1; md[i] = idat[i]; acc[i] = 1'b1; lacc[i] = cyc;
          if (i == 0) sb0.push_back('{idat[i], cyc});
          else        sb1.push_back('{idat[i], cyc});
        end
      end else begin
        mk[i]++;
        if (mk[i] > per(i)) begin mb[i] = 1'b0; mk[i] = 0; end
      end
    end
    if (rst) begin sb0.delete(); sb1.delete(); end
  end

  // Monitor: per-cycle output check plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        bit   exp_e, exp_done;
        rec_t r;
        exp_e    = mb[i] && (mk[i] >= sp(i) + 1) && (mk[i] <= sp(i) + pp(i));
        exp_done = mb[i] && (mk[i] == per(i));
        if (oe[i] === 1'b1) q[i] = od[i];
        if (exp_e) begin mq[i] = md[i]; mqv[i] = 1'b1; end
        check("e", i, 32'(oe[i]), 32'(exp_e));
        check("done", i, 32'(odone[i]), 32'(exp_done));
        check("busy", i, 32'(obusy[i]), 32'(mb[i]));
        check("in_ready", i, 32'(ordy[i]), 32'(!mb[i]));
        check("d", i, 32'(od[i]), 32'(md[i]));
        if (mqv[i]) check("latch_q", i, 32'(q[i]), 32'(mq[i]));
        if (odone[i] === 1'b1) begin
          if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
            check("sb_nonempty", i, 32'd0, 32'd1);
          end else begin
            r = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            check("sb_q", i, 32'(q[i]), 32'(r.data));
            check("sb_latency", i, 32'(cyc - r.acc), 32'(per(i)));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int i, input logic [7:0] w, input bit keep, output int t);
    iv[i] = 1'b1; idat[i] = w;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (acc[i]) break;
    end
    check("accept", i, 32'(acc[i]), 32'd1);
    t = lacc[i];
    if (!keep) iv[i] = 1'b0;
  endtask

  task automatic rand_run(input int i, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      send(i, 8'($urandom), 1'b0, t);
      step($urandom_range(0, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3;
    iv[0] = 1'b0; iv[1] = 1'b0; idat[0] = '0; idat[1] = '0;

    // Reset with no clock edge: outputs must settle immediately.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_e", i, 32'(oe[i]), 32'd0);
      check("rst_d", i, 32'(od[i]), 32'd0);
      check("rst_ready", i, 32'(ordy[i]), 32'd1);
      check("rst_busy", i, 32'(obusy[i]), 32'd0);
      check("rst_done", i, 32'(odone[i]), 32'd0);
    end
    step(2);
    rst = 1'b0;
    step(1);

    // Single word.
    send(0, 8'hA5, 1'b0, t1);
    step(8);

    // Back-to-back with valid held: minimum period.
    send(0, 8'h3C, 1'b1, t1);
    send(0, 8'hC3, 1'b0, t2);
    check("period_default", 0, 32'(t2 - t1), 32'd7);
    step(8);

    // Input noise while busy must be ignored.
    send(0, 8'h96, 1'b0, t1);
    repeat (6) begin
      iv[0] = 1'($urandom); idat[0] = 8'($urandom);
      step(1);
    end
    iv[0] = 1'b0;
    step(3);

    // Random traffic on both instances concurrently.
    fork
      rand_run(0, 12);
      rand_run(1, 12);
    join
    step(8);

    // Reset mid-strobe: e must drop at once, then a clean frame follows.
    send(0, 8'h11, 1'b0, t1);
    step(3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_e", 0, 32'(oe[0]), 32'd0);
    check("rst_mid_busy", 0, 32'(obusy[0]), 32'd0);
    check("rst_mid_ready", 0, 32'(ordy[0]), 32'd1);
    check("rst_mid_d", 0, 32'(od[0]), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    send(0, 8'h5A, 1'b0, t1);
    step(8);

    // Shortest timing: period of 4 with valid held.
    send(1, 8'hE1, 1'b1, t1);
    send(1, 8'h1E, 1'b1, t2);
    send(1, 8'h77, 1'b0, t3);
    check("period_min_a", 1, 32'(t2 - t1), 32'd4);
    check("period_min_b", 1, 32'(t3 - t2), 32'd4);
    step(6);

    check("sb_drained", 0, 32'(sb0.size()), 32'd0);
    check("sb_drained", 1, 32'(sb1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
